// File: rtl/mem_io_responder.sv
// +----------------------------------------------------------------------------+
// | Module      : mem_io_responder                                             |
// | Description : Target side of the CPU byte-wide memory bus. Provides main   |
// |               RAM, decodes the I/O window at 0x30000 (UART TX/RX FIFOs,    |
// |               cycle-counter snapshot, program-stop flag) and drives        |
// |               io_buffer_full back to the core.                             |
// |               Optional feature macro: MEMIO_CYCLE_CNT_EN (free-running     |
// |               cycle counter and snapshot readable at 0x30004..0x30007).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_io_responder #(
  parameter int RAM_ADDR_W   = 17,
  parameter int TX_DEPTH_LOG = 3,
  parameter int RX_DEPTH_LOG = 3
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        program_stop
);

  localparam int                  c_TX_DEPTH  = 1 << TX_DEPTH_LOG;
  localparam int                  c_RX_DEPTH  = 1 << RX_DEPTH_LOG;
  localparam logic [TX_DEPTH_LOG:0] c_TX_FULL   = (TX_DEPTH_LOG+1)'(c_TX_DEPTH);
  // Two-entry margin so a core write already in flight still fits.
  localparam logic [TX_DEPTH_LOG:0] c_TX_THRESH = (TX_DEPTH_LOG+1)'(c_TX_DEPTH - 2);
  localparam logic [RX_DEPTH_LOG:0] c_RX_FULL   = (RX_DEPTH_LOG+1)'(c_RX_DEPTH);

  // Storage (not reset)
  logic [7:0] r_ram    [0:(1<<RAM_ADDR_W)-1];
  logic [7:0] r_tx_mem [0:c_TX_DEPTH-1];
  logic [7:0] r_rx_mem [0:c_RX_DEPTH-1];

  // FIFO pointers and occupancy counts
  logic [TX_DEPTH_LOG-1:0] r_tx_wr, r_tx_rd;
  logic [TX_DEPTH_LOG:0]   r_tx_cnt, w_tx_cnt_nxt;
  logic [RX_DEPTH_LOG-1:0] r_rx_wr, r_rx_rd;
  logic [RX_DEPTH_LOG:0]   r_rx_cnt, w_rx_cnt_nxt;

  // Address decode
  logic w_io, w_io_data, w_io_cnt, w_io_stop;
  logic w_ram_we;
  logic w_tx_push_req, w_tx_push, w_tx_pop, w_tx_empty, w_tx_full;
  logic [7:0] w_tx_push_data;
  logic w_rx_push, w_rx_pop, w_rx_empty, w_rx_full;
  logic [7:0] w_rd_data;
  logic w_unused_addr;

`ifdef MEMIO_CYCLE_CNT_EN
  logic [31:0] r_cnt;
  logic [31:0] r_snap;
`endif

  assign w_unused_addr = ^cpu_a[31:18];

  assign w_io      = (cpu_a[17:16] == 2'b11);
  assign w_io_data = w_io & (cpu_a[15:0] == 16'h0000);
  assign w_io_cnt  = w_io & (cpu_a[15:2] == 14'd1);
  assign w_io_stop = w_io_cnt & (cpu_a[1:0] == 2'b00);

  assign w_ram_we  = cpu_wr & rdy_in & ~w_io;

  // TX side: zero bytes to the data port are ignored; the stop write injects a 0x00 marker.
  assign w_tx_empty     = (r_tx_cnt == '0);
  assign w_tx_full      = (r_tx_cnt == c_TX_FULL);
  assign w_tx_push_req  = cpu_wr & rdy_in & ((w_io_data & (cpu_wdata != 8'h00)) | w_io_stop);
  assign w_tx_push_data = w_io_stop ? 8'h00 : cpu_wdata;
  assign w_tx_pop       = ~w_tx_empty & tx_ready;
  assign w_tx_push      = w_tx_push_req & (~w_tx_full | w_tx_pop);

  // RX side: the core pops by reading the data port; the receiver pushes whenever it has a byte.
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == c_RX_FULL);
  assign w_rx_pop   = ~cpu_wr & rdy_in & w_io_data & ~w_rx_empty;
  assign w_rx_push  = rx_valid & (~w_rx_full | w_rx_pop);

  assign tx_valid = ~w_tx_empty;
  assign tx_data  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd];

  // Next TX occupancy; push and pop together leave it unchanged
  always_comb begin
    w_tx_cnt_nxt = r_tx_cnt;
    case ({w_tx_push, w_tx_pop})
      2'b10:   w_tx_cnt_nxt = r_tx_cnt + (TX_DEPTH_LOG+1)'(1);
      2'b01:   w_tx_cnt_nxt = r_tx_cnt - (TX_DEPTH_LOG+1)'(1);
      default: w_tx_cnt_nxt = r_tx_cnt;
    endcase
  end

  // Next RX occupancy; push and pop together leave it unchanged
  always_comb begin
    w_rx_cnt_nxt = r_rx_cnt;
    case ({w_rx_push, w_rx_pop})
      2'b10:   w_rx_cnt_nxt = r_rx_cnt + (RX_DEPTH_LOG+1)'(1);
      2'b01:   w_rx_cnt_nxt = r_rx_cnt - (RX_DEPTH_LOG+1)'(1);
      default: w_rx_cnt_nxt = r_rx_cnt;
    endcase
  end

  // Read-data multiplexer for the request presented this cycle
  always_comb begin
    w_rd_data = 8'h00;
    if (!w_io) begin
      w_rd_data = r_ram[cpu_a[RAM_ADDR_W-1:0]];
    end else if (w_io_data) begin
      w_rd_data = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd];
    end else if (w_io_cnt) begin
`ifdef MEMIO_CYCLE_CNT_EN
      // 0x30004 returns the live counter byte while the snapshot is being taken
      case (cpu_a[1:0])
        2'b00:   w_rd_data = r_cnt[7:0];
        2'b01:   w_rd_data = r_snap[15:8];
        2'b10:   w_rd_data = r_snap[23:16];
        default: w_rd_data = r_snap[31:24];
      endcase
`else
      w_rd_data = 8'h00;
`endif
    end
  end

  // RAM write port
  always_ff @(posedge clk_in) begin
    if (w_ram_we) r_ram[cpu_a[RAM_ADDR_W-1:0]] <= cpu_wdata;
  end

  // FIFO storage writes
  always_ff @(posedge clk_in) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= w_tx_push_data;
    if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
  end

  // Registered read data; a write cycle leaves the previous value in place
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cpu_rdata <= 8'h00;
    end else if (!cpu_wr) begin
      cpu_rdata <= w_rd_data;
    end
  end

  // TX FIFO pointers, count and the near-full flag
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tx_wr        <= '0;
      r_tx_rd        <= '0;
      r_tx_cnt       <= '0;
      io_buffer_full <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + TX_DEPTH_LOG'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + TX_DEPTH_LOG'(1);
      r_tx_cnt       <= w_tx_cnt_nxt;
      io_buffer_full <= (w_tx_cnt_nxt >= c_TX_THRESH);
    end
  end

  // RX FIFO pointers and count
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + RX_DEPTH_LOG'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + RX_DEPTH_LOG'(1);
      r_rx_cnt <= w_rx_cnt_nxt;
    end
  end

  // Sticky program-stop flag
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      program_stop <= 1'b0;
    end else if (cpu_wr && rdy_in && w_io_stop) begin
      program_stop <= 1'b1;
    end
  end

`ifdef MEMIO_CYCLE_CNT_EN
  // Free-running cycle counter and snapshot taken on a read of 0x30004
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt  <= 32'h0000_0000;
      r_snap <= 32'h0000_0000;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (!cpu_wr && rdy_in && w_io_stop) r_snap <= r_cnt;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_io_responder.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_io_responder                                          |
// | Description : Directed self-checking bench for mem_io_responder; expected  |
// |               read and TX bytes are queued at stimulus time and compared   |
// |               when the DUT produces them. Honors MEMIO_CYCLE_CNT_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        program_stop;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] m_cnt;
  logic [31:0] snap;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .cpu_a          (cpu_a),
    .cpu_wr         (cpu_wr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .program_stop   (program_stop)
  );

  always #5 clk_in = ~clk_in;

  // Reference cycle count since reset release
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) m_cnt <= 32'h0;
    else           m_cnt <= m_cnt + 32'd1;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Idle bus: read of an unmapped I/O address (returns 0x00, no side effects)
  task automatic idle();
    cpu_a     = 32'h0003_000C;
    cpu_wr    = 1'b0;
    cpu_wdata = 8'h00;
    rdy_in    = 1'b1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d, input logic rdy = 1'b1);
    cpu_a = a; cpu_wr = 1'b1; cpu_wdata = d; rdy_in = rdy;
    @(negedge clk_in);
    idle();
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [7:0] exp);
    cpu_a = a; cpu_wr = 1'b0; rdy_in = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk_in);
    idle();
    chk(tag, cpu_rdata, rd_q.pop_front());
  endtask

  // Drain the TX FIFO, comparing each accepted byte against the queue
  task automatic drain_tx(input string tag);
    tx_ready = 1'b1;
    for (int k = 0; k < 40 && tx_valid; k++) begin
      chk(tag, {1'b0, tx_data}, (tx_q.size() != 0) ? {1'b0, tx_q.pop_front()} : 9'h100);
      @(negedge clk_in);
    end
    tx_ready = 1'b0;
    chk({tag, "_left"}, tx_q.size(), 0);
    chk({tag, "_valid"}, tx_valid, 1'b0);
  endtask

  initial begin
    rst_n_in = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle();
    repeat (3) @(negedge clk_in);

    // Reset state
    chk("rst_rdata", cpu_rdata, 8'h00);
    chk("rst_full",  io_buffer_full, 1'b0);
    chk("rst_txv",   tx_valid, 1'b0);
    chk("rst_txd",   tx_data, 8'h00);
    chk("rst_stop",  program_stop, 1'b0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // RAM write then read, write cycle holds rdata, rdy_in gates writes
    wr(32'h0000_0100, 8'hA5);
    rd("ram_rd", 32'h0000_0100, 8'hA5);
    wr(32'h0000_0100, 8'h5C);
    chk("wr_hold", cpu_rdata, 8'hA5);
    rd("ram_rd2", 32'h0000_0100, 8'h5C);
    wr(32'h0000_0200, 8'h11);
    wr(32'h0000_0200, 8'h22, 1'b0);
    rd("ram_nordy", 32'h0000_0200, 8'h11);

    // TX: zero bytes ignored
    wr(32'h0003_0000, 8'h41); tx_q.push_back(8'h41);
    wr(32'h0003_0000, 8'h00);
    wr(32'h0003_0000, 8'h42); tx_q.push_back(8'h42);
    chk("tx_valid", tx_valid, 1'b1);
    chk("tx_head", tx_data, 8'h41);
    chk("tx_nfull", io_buffer_full, 1'b0);
    drain_tx("tx_a");

    // TX near-full flag and overflow drop
    for (int i = 1; i <= 9; i++) begin
      wr(32'h0003_0000, 8'(i));
      if (i <= 8) tx_q.push_back(8'(i));
      if (i == 5) chk("full_at5", io_buffer_full, 1'b0);
      if (i == 6) chk("full_at6", io_buffer_full, 1'b1);
    end
    drain_tx("tx_b");
    chk("full_clr", io_buffer_full, 1'b0);

    // Writes to unmapped I/O are ignored
    wr(32'h0003_0008, 8'h77);
    chk("io_unmapped_wr", tx_valid, 1'b0);

    // RX single byte, then empty read
    rx_valid = 1'b1; rx_data = 8'h37;
    @(negedge clk_in);
    rx_valid = 1'b0;
    rd("rx_one", 32'h0003_0000, 8'h37);
    rd("rx_empty", 32'h0003_0000, 8'h00);

    // RX overflow: ninth byte dropped
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'h50 + 8'(i);
      @(negedge clk_in);
    end
    rx_valid = 1'b0;
    for (int i = 0; i < 9; i++) rd("rx_ovf", 32'h0003_0000, (i < 8) ? 8'h50 + 8'(i) : 8'h00);

    // Counter snapshot at 0x123
    for (int k = 0; k < 2000 && m_cnt != 32'h123; k++) @(negedge clk_in);
    if (m_cnt != 32'h123) begin
      total++; bad++;
      $error("FAIL cnt_reach observed=%h expected=%h", m_cnt, 32'h123);
    end
`ifdef MEMIO_CYCLE_CNT_EN
    snap = m_cnt;
`else
    snap = 32'h0;
`endif
    rd("snap0", 32'h0003_0004, snap[7:0]);
    rd("snap1", 32'h0003_0005, snap[15:8]);
    rd("snap2", 32'h0003_0006, snap[23:16]);
    rd("snap3", 32'h0003_0007, snap[31:24]);
    rd("io_other", 32'h0003_0001, 8'h00);

    // Program stop with 0x00 marker
    chk("stop_pre", program_stop, 1'b0);
    wr(32'h0003_0004, 8'h99); tx_q.push_back(8'h00);
    chk("stop_set", program_stop, 1'b1);
    chk("stop_txv", tx_valid, 1'b1);
    chk("stop_txd", tx_data, 8'h00);
    drain_tx("tx_stop");
    chk("stop_sticky", program_stop, 1'b1);

    // Asynchronous reset in the middle of a write burst
    rd("pre_rst", 32'h0000_0100, 8'h5C);
    for (int i = 0; i < 6; i++) wr(32'h0003_0000, 8'h61 + 8'(i));
    chk("burst_full", io_buffer_full, 1'b1);
    cpu_a = 32'h0003_0000; cpu_wr = 1'b1; cpu_wdata = 8'h70;
    #2 rst_n_in = 1'b0;
    #1;
    chk("arst_rdata", cpu_rdata, 8'h00);
    chk("arst_full",  io_buffer_full, 1'b0);
    chk("arst_txv",   tx_valid, 1'b0);
    chk("arst_txd",   tx_data, 8'h00);
    chk("arst_stop",  program_stop, 1'b0);
    idle();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tx_q.delete();
    @(negedge clk_in);
    chk("post_rst_txv", tx_valid, 1'b0);
    rd("post_rst_ram", 32'h0000_0100, 8'h5C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
